rv32i_core_pc: RTL and testbench



---
 rtl/rv32i_pkg.sv | 65 ++++++
 rtl/rv32i_regfile.sv | 30 +++
 rtl/rv32i_core_pc.sv | 139 +++++++++++++
 tb/tb_rv32i_core_pc.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU operations
// and the boot ROM image of the first execution slice.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // alt is instr[30], already masked by the caller where it is an immediate bit
    function automatic alu_op_e alu_decode(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_op_e op;
        unique case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] boot_word(input int unsigned idx);
        logic [31:0] w;
        unique case (idx)
            0:       w = 32'h00500093;
            1:       w = 32'h00800113;
            2:       w = 32'h002081B3;
            3:       w = 32'h4011D213;
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// x0 hardwired to zero, synchronous clear.
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/rv32i_core_pc.sv
// Single-cycle RV32I core slice: PC, instruction ROM, decoder, ALU,
// register file; every retirement is visible on the dbg_* outputs.
module rv32i_core_pc
    import rv32i_pkg::*;
#(
    parameter int                       IMEM_WORDS = 16,
    parameter bit                       USE_IMAGE  = 1'b0,
    parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE  = '0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_instr,
    output logic [4:0]  dbg_rd,
    output logic        dbg_reg_write,
    output logic [31:0] dbg_wd
);

    localparam int IDX_W = $clog2(IMEM_WORDS);

    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rom [IMEM_WORDS];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [4:0]  shamt;
    alu_op_e     alu_op;
    logic        writes;
    logic        reg_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_rom
        assign rom[i] = USE_IMAGE ? ROM_IMAGE[i*32 +: 32] : boot_word(i);
    end

    // Fetch past the end of the ROM yields NOPs forever
    always_comb begin
        instr = NOP_INSTR;
        if ({2'b00, pc[31:2]} < 32'(IMEM_WORDS)) begin
            instr = rom[pc[IDX_W+1:2]];
        end
    end

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'h000};

    rv32i_regfile u_rf (
        .clk (clk),
        .rst (rst),
        .we  (reg_write),
        .wa  (rd),
        .wd  (alu_y),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val)
    );

    always_comb begin
        alu_a  = rs1_val;
        alu_b  = rs2_val;
        alu_op = ALU_ADD;
        writes = 1'b0;
        unique case (1'b1)
            (opcode == OP): begin
                alu_op = alu_decode(f3, instr[30]);
                writes = 1'b1;
            end
            (opcode == OP_IMM): begin
                alu_b  = imm_i;
                alu_op = alu_decode(f3, instr[30] && f3 == F3_SR);
                writes = 1'b1;
            end
            (opcode == LUI): begin
                alu_a  = '0;
                alu_b  = imm_u;
                writes = 1'b1;
            end
            (opcode == AUIPC): begin
                alu_a  = pc;
                alu_b  = imm_u;
                writes = 1'b1;
            end
            default: ;
        endcase
    end

    assign shamt = alu_b[4:0];

    always_comb begin
        alu_y = '0;
        unique case (alu_op)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_SLL:  alu_y = alu_a << shamt;
            ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_SRL:  alu_y = alu_a >> shamt;
            ALU_SRA:  alu_y = 32'($signed(alu_a) >>> shamt);
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            default:  alu_y = '0;
        endcase
    end

    assign reg_write = writes && rd != 5'd0 && !rst;

    assign dbg_pc        = pc;
    assign dbg_instr     = instr;
    assign dbg_rd        = rd;
    assign dbg_reg_write = reg_write;
    assign dbg_wd        = reg_write ? alu_y : '0;

endmodule

// File: tb/tb_rv32i_core_pc.sv
// Bench for rv32i_core_pc: boot ROM and an ALU image run in lockstep
// against an instruction-level model, plus vector tables and reset cases.
module tb_rv32i_core_pc;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int ALT_WORDS = 24;

    function automatic logic [31:0] enc_r(
        input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd
    );
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd
    );
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_u(
        input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc
    );
        return {imm, rd, opc};
    endfunction

    function automatic logic [ALT_WORDS*32-1:0] build_alt();
        logic [ALT_WORDS*32-1:0] img;
        img = '0;
        img[32*0  +: 32] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
        img[32*1  +: 32] = enc_i(12'd8, 5'd0, 3'd0, 5'd2);
        img[32*2  +: 32] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5);
        img[32*3  +: 32] = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd6);
        img[32*4  +: 32] = enc_u(20'h00001, 5'd7, 7'h17);
        img[32*5  +: 32] = enc_r(7'h00, 5'd2, 5'd5, 3'd3, 5'd8);
        img[32*6  +: 32] = enc_u(20'h80000, 5'd9, 7'h37);
        img[32*7  +: 32] = enc_i(12'h001, 5'd9, 3'd5, 5'd10);
        img[32*8  +: 32] = enc_i(12'd1, 5'd0, 3'd0, 5'd11);
        img[32*9  +: 32] = enc_r(7'h00, 5'd11, 5'd9, 3'd5, 5'd12);
        img[32*10 +: 32] = enc_r(7'h20, 5'd11, 5'd9, 3'd5, 5'd13);
        img[32*11 +: 32] = enc_u(20'h12345, 5'd14, 7'h37);
        img[32*12 +: 32] = enc_i(12'h41F, 5'd9, 3'd5, 5'd15);
        img[32*13 +: 32] = enc_r(7'h00, 5'd5, 5'd14, 3'd4, 5'd16);
        img[32*14 +: 32] = enc_i(12'hFFF, 5'd5, 3'd2, 5'd17);
        img[32*15 +: 32] = enc_i(12'hFFF, 5'd5, 3'd3, 5'd18);
        img[32*16 +: 32] = enc_r(7'h00, 5'd2, 5'd11, 3'd1, 5'd19);
        img[32*17 +: 32] = enc_r(7'h00, 5'd19, 5'd14, 3'd6, 5'd20);
        img[32*18 +: 32] = enc_r(7'h00, 5'd5, 5'd20, 3'd7, 5'd21);
        img[32*19 +: 32] = enc_i(12'hFFF, 5'd14, 3'd4, 5'd22);
        img[32*20 +: 32] = enc_i(12'h7FF, 5'd0, 3'd6, 5'd23);
        img[32*21 +: 32] = enc_i(12'h0F0, 5'd22, 3'd7, 5'd24);
        img[32*22 +: 32] = enc_i(12'h01F, 5'd11, 3'd1, 5'd25);
        img[32*23 +: 32] = 32'hFFFFFFFF;
        return img;
    endfunction

    localparam logic [ALT_WORDS*32-1:0] ALT_IMAGE = build_alt();

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_pc, d_instr, d_wd;
    logic [4:0]  d_rd;
    logic        d_we;
    logic [31:0] a_pc, a_instr, a_wd;
    logic [4:0]  a_rd;
    logic        a_we;

    always #5 clk = ~clk;

    rv32i_core_pc u_dut (
        .clk           (clk),
        .rst           (rst),
        .dbg_pc        (d_pc),
        .dbg_instr     (d_instr),
        .dbg_rd        (d_rd),
        .dbg_reg_write (d_we),
        .dbg_wd        (d_wd)
    );

    rv32i_core_pc #(
        .IMEM_WORDS (ALT_WORDS),
        .USE_IMAGE  (1'b1),
        .ROM_IMAGE  (ALT_IMAGE)
    ) u_alt (
        .clk           (clk),
        .rst           (rst),
        .dbg_pc        (a_pc),
        .dbg_instr     (a_instr),
        .dbg_rd        (a_rd),
        .dbg_reg_write (a_we),
        .dbg_wd        (a_wd)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wd;
    } retire_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_valid  = 1'b0;
    logic [31:0] m_pc   [2];
    logic [31:0] m_regs [2][32];
    vec_t        alt_tab [ALT_WORDS];
    vec_t        def_tab [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fetch(input int c, input logic [31:0] pc);
        logic [31:0] idx;
        idx = pc >> 2;
        if (c == 0) begin
            case (idx)
                0: return 32'h00500093;
                1: return 32'h00800113;
                2: return 32'h002081B3;
                3: return 32'h4011D213;
                default: return NOP;
            endcase
        end
        if (idx < ALT_WORDS) return ALT_IMAGE[idx*32 +: 32];
        return NOP;
    endfunction

    function automatic logic [31:0] alu(
        input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b
    );
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            3'd3: return {31'd0, a < b};
            3'd4: return a ^ b;
            3'd5: return alt ? ((a >> sh) | ({32{a[31]}} & ~(32'hFFFFFFFF >> sh))) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic retire_t predict(input int c);
        retire_t     r;
        logic [31:0] a, b, v, immi, immu;
        logic        ok;
        r.pc    = m_pc[c];
        r.instr = fetch(c, m_pc[c]);
        r.rd    = r.instr[11:7];
        a    = m_regs[c][r.instr[19:15]];
        b    = m_regs[c][r.instr[24:20]];
        immi = {{20{r.instr[31]}}, r.instr[31:20]};
        immu = {r.instr[31:12], 12'h000};
        ok   = 1'b1;
        v    = '0;
        case (r.instr[6:0])
            7'h33: v = alu(r.instr[14:12], r.instr[30], a, b);
            7'h13: v = alu(r.instr[14:12], r.instr[30] && r.instr[14:12] == 3'd5, a, immi);
            7'h37: v = immu;
            7'h17: v = r.pc + immu;
            default: ok = 1'b0;
        endcase
        r.we = ok && r.rd != 5'd0;
        r.wd = r.we ? v : '0;
        return r;
    endfunction

    task automatic settle(input bit r);
        rst = r;
        #1;
    endtask

    task automatic check_model(input bit r);
        retire_t e;
        retire_t g;
        string   t;
        if (!m_valid) return;
        for (int c = 0; c < 2; c++) begin
            e = predict(c);
            if (r) begin
                e.we = 1'b0;
                e.wd = '0;
            end
            if (c == 0) begin
                g = '{d_pc, d_instr, d_rd, d_we, d_wd};
                t = "boot";
            end else begin
                g = '{a_pc, a_instr, a_rd, a_we, a_wd};
                t = "alu";
            end
            chk({t, ".pc"}, g.pc, e.pc);
            chk({t, ".instr"}, g.instr, e.instr);
            chk({t, ".rd"}, {27'd0, g.rd}, {27'd0, e.rd});
            chk({t, ".we"}, {31'd0, g.we}, {31'd0, e.we});
            chk({t, ".wd"}, g.wd, e.wd);
        end
    endtask

    task automatic advance(input bit r);
        retire_t e;
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                m_pc[c] = '0;
                for (int k = 0; k < 32; k++) m_regs[c][k] = '0;
            end else begin
                e = predict(c);
                if (e.we) m_regs[c][e.rd] = e.wd;
                m_pc[c] = m_pc[c] + 32'd4;
            end
        end
        m_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input bit r);
        settle(r);
        check_model(r);
        advance(r);
    endtask

    initial begin
        def_tab[0] = '{1'b1, 5'd1, 32'd5};
        def_tab[1] = '{1'b1, 5'd2, 32'd8};
        def_tab[2] = '{1'b1, 5'd3, 32'd13};
        def_tab[3] = '{1'b1, 5'd4, 32'd6};

        alt_tab[0]  = '{1'b1, 5'd1,  32'd5};
        alt_tab[1]  = '{1'b1, 5'd2,  32'd8};
        alt_tab[2]  = '{1'b1, 5'd5,  32'hFFFFFFFD};
        alt_tab[3]  = '{1'b1, 5'd6,  32'd1};
        alt_tab[4]  = '{1'b1, 5'd7,  32'h00001010};
        alt_tab[5]  = '{1'b1, 5'd8,  32'd0};
        alt_tab[6]  = '{1'b1, 5'd9,  32'h80000000};
        alt_tab[7]  = '{1'b1, 5'd10, 32'h40000000};
        alt_tab[8]  = '{1'b1, 5'd11, 32'd1};
        alt_tab[9]  = '{1'b1, 5'd12, 32'h40000000};
        alt_tab[10] = '{1'b1, 5'd13, 32'hC0000000};
        alt_tab[11] = '{1'b1, 5'd14, 32'h12345000};
        alt_tab[12] = '{1'b1, 5'd15, 32'hFFFFFFFF};
        alt_tab[13] = '{1'b1, 5'd16, 32'hEDCBAFFD};
        alt_tab[14] = '{1'b1, 5'd17, 32'd1};
        alt_tab[15] = '{1'b1, 5'd18, 32'd1};
        alt_tab[16] = '{1'b1, 5'd19, 32'h00000100};
        alt_tab[17] = '{1'b1, 5'd20, 32'h12345100};
        alt_tab[18] = '{1'b1, 5'd21, 32'h12345100};
        alt_tab[19] = '{1'b1, 5'd22, 32'hEDCBAFFF};
        alt_tab[20] = '{1'b1, 5'd23, 32'h000007FF};
        alt_tab[21] = '{1'b1, 5'd24, 32'h000000F0};
        alt_tab[22] = '{1'b1, 5'd25, 32'h80000000};
        alt_tab[23] = '{1'b0, 5'd31, 32'd0};

        step(1'b1);
        step(1'b1);

        for (int i = 0; i < ALT_WORDS; i++) begin
            settle(1'b0);
            check_model(1'b0);
            chk("tab.pc", a_pc, 32'(i * 4));
            chk("tab.we", {31'd0, a_we}, {31'd0, alt_tab[i].we});
            chk("tab.rd", {27'd0, a_rd}, {27'd0, alt_tab[i].rd});
            chk("tab.wd", a_wd, alt_tab[i].wd);
            if (i < 4) begin
                chk("boot.we", {31'd0, d_we}, {31'd0, def_tab[i].we});
                chk("boot.rd", {27'd0, d_rd}, {27'd0, def_tab[i].rd});
                chk("boot.wd", d_wd, def_tab[i].wd);
            end else begin
                chk("boot.nop", d_instr, NOP);
                chk("boot.nowr", {31'd0, d_we}, 32'd0);
            end
            advance(1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            settle(1'b0);
            chk("past_rom.pc", d_pc, 32'(96 + 4 * i));
            chk("past_rom.alt_nop", a_instr, NOP);
            check_model(1'b0);
            advance(1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            settle(1'b1);
            check_model(1'b1);
            if (i > 0) chk("held.pc", d_pc, 32'd0);
            chk("held.we", {31'd0, d_we}, 32'd0);
            advance(1'b1);
        end

        step(1'b0);
        step(1'b0);
        settle(1'b1);
        chk("midrst.pc", d_pc, 32'd8);
        chk("midrst.we", {31'd0, d_we}, 32'd0);
        check_model(1'b1);
        advance(1'b1);
        settle(1'b0);
        chk("restart.pc", d_pc, 32'd0);
        chk("restart.x1", u_dut.u_rf.regs[1], 32'd0);
        check_model(1'b0);
        advance(1'b0);
        settle(1'b0);
        chk("rewrite.x1", u_dut.u_rf.regs[1], 32'd5);
        check_model(1'b0);
        advance(1'b0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
